// File: rtl/cpu_axi_bridge_if.sv
// Core-side SRAM-like ports and the single-beat AXI3 master signals.
// master = bridge side; slave = core plus interconnect side.
interface cpu_axi_bridge_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;

  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata,
    input  data_req,
    input  data_wr,
    input  data_size,
    input  data_wstrb,
    input  data_addr,
    input  data_wdata,
    output data_addr_ok,
    output data_data_ok,
    output data_rdata,
    output arid,
    output araddr,
    output arsize,
    output arvalid,
    input  arready,
    input  rid,
    input  rdata,
    input  rvalid,
    output rready,
    output awaddr,
    output awsize,
    output awvalid,
    input  awready,
    output wdata,
    output wstrb,
    output wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata,
    output data_req,
    output data_wr,
    output data_size,
    output data_wstrb,
    output data_addr,
    output data_wdata,
    input  data_addr_ok,
    input  data_data_ok,
    input  data_rdata,
    input  arid,
    input  araddr,
    input  arsize,
    input  arvalid,
    output arready,
    output rid,
    output rdata,
    output rvalid,
    input  rready,
    input  awaddr,
    input  awsize,
    input  awvalid,
    output awready,
    input  wdata,
    input  wstrb,
    input  wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: inst/data SRAM-like ports to one AXI3 master, single beat.
// Optional perf counters enabled by BRIDGE_PERF_CNT_EN.
module cpu_axi_bridge #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
`ifdef BRIDGE_PERF_CNT_EN
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  cpu_axi_bridge_if.master bus
);

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_R
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_B
  } wstate_t;

  rstate_t     r_rst;
  logic [31:0] r_araddr;
  logic [3:0]  r_arid;
  logic [2:0]  r_arsize;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_rd_data;

  wstate_t     r_wst;
  logic [31:0] r_awaddr;
  logic [2:0]  r_awsize;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;

  logic w_rd_idle;
  logic w_wr_idle;
  logic w_data_rd_cand;
  logic w_rd_data_acc;
  logic w_rd_inst_acc;
  logic w_rd_data_busy;
  logic w_wr_acc;
  logic w_r_hs;
  logic w_r_is_data;
  logic w_r_data;
  logic w_r_inst;
  logic w_b_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_done;
  logic w_w_done;

  assign w_rd_idle = (r_rst == R_IDLE);
  assign w_wr_idle = (r_wst == W_IDLE);

  // Loads wait for any outstanding store to finish (no RAW forwarding).
  assign w_data_rd_cand = bus.data_req & ~bus.data_wr & w_wr_idle;

  assign w_rd_data_acc = w_rd_idle & w_data_rd_cand;
  assign w_rd_inst_acc = w_rd_idle & bus.inst_req
                       & ~w_data_rd_cand;

  assign w_rd_data_busy = ~w_rd_idle & r_rd_data;
  assign w_wr_acc = w_wr_idle & bus.data_req
                  & bus.data_wr & ~w_rd_data_busy;

  assign w_r_hs      = r_rready & bus.rvalid;
  assign w_r_is_data = (bus.rid == ID_DATA);
  assign w_r_data    = w_r_hs & w_r_is_data;
  assign w_r_inst    = w_r_hs & ~w_r_is_data;

  assign w_b_hs  = r_bready & bus.bvalid;
  assign w_aw_hs = r_awvalid & bus.awready;
  assign w_w_hs  = r_wvalid & bus.wready;

  assign w_aw_done = ~r_awvalid | w_aw_hs;
  assign w_w_done  = ~r_wvalid | w_w_hs;

  assign bus.inst_addr_ok = w_rd_inst_acc;
  assign bus.inst_data_ok = w_r_inst;
  assign bus.inst_rdata   = w_r_inst ? bus.rdata : '0;

  assign bus.data_addr_ok = w_rd_data_acc | w_wr_acc;
  assign bus.data_data_ok = w_r_data | w_b_hs;
  assign bus.data_rdata   = w_r_data ? bus.rdata : '0;

  assign bus.arid    = r_arid;
  assign bus.araddr  = r_araddr;
  assign bus.arsize  = r_arsize;
  assign bus.arvalid = r_arvalid;
  assign bus.rready  = r_rready;

  assign bus.awaddr  = r_awaddr;
  assign bus.awsize  = r_awsize;
  assign bus.awvalid = r_awvalid;
  assign bus.wdata   = r_wdata;
  assign bus.wstrb   = r_wstrb;
  assign bus.wvalid  = r_wvalid;
  assign bus.bready  = r_bready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rst     <= R_IDLE;
      r_araddr  <= '0;
      r_arid    <= '0;
      r_arsize  <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rd_data <= 1'b0;
    end else begin
      unique case (r_rst)
        R_IDLE: begin
          if (w_rd_data_acc) begin
            r_araddr  <= bus.data_addr;
            r_arid    <= ID_DATA;
            r_arsize  <= {1'b0, bus.data_size};
            r_rd_data <= 1'b1;
            r_arvalid <= 1'b1;
            r_rst     <= R_AR;
          end else if (w_rd_inst_acc) begin
            r_araddr  <= bus.inst_addr;
            r_arid    <= ID_INST;
            r_arsize  <= 3'd2;
            r_rd_data <= 1'b0;
            r_arvalid <= 1'b1;
            r_rst     <= R_AR;
          end
        end
        R_AR: begin
          if (bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_rst     <= R_R;
          end
        end
        R_R: begin
          if (bus.rvalid) begin
            r_rready <= 1'b0;
            r_rst    <= R_IDLE;
          end
        end
        default: begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_rst     <= R_IDLE;
        end
      endcase
    end
  end

  // AW and W retire independently; B is awaited once both are done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wst     <= W_IDLE;
      r_awaddr  <= '0;
      r_awsize  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
    end else begin
      unique case (r_wst)
        W_IDLE: begin
          if (w_wr_acc) begin
            r_awaddr  <= bus.data_addr;
            r_awsize  <= {1'b0, bus.data_size};
            r_wdata   <= bus.data_wdata;
            r_wstrb   <= bus.data_wstrb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_wst     <= W_SEND;
          end
        end
        W_SEND: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_done & w_w_done) begin
            r_bready <= 1'b1;
            r_wst    <= W_B;
          end
        end
        W_B: begin
          if (bus.bvalid) begin
            r_bready <= 1'b0;
            r_wst    <= W_IDLE;
          end
        end
        default: begin
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
          r_wst     <= W_IDLE;
        end
      endcase
    end
  end

`ifdef BRIDGE_PERF_CNT_EN
  logic w_i_stall;
  logic w_d_stall;

  assign w_i_stall = bus.inst_req & ~w_rd_inst_acc;
  assign w_d_stall = bus.data_req & ~bus.data_addr_ok;

  // Stall count adds one per stalled port, so both stalling adds two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_rd_cnt    <= '0;
      perf_wr_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_r_hs) perf_rd_cnt <= perf_rd_cnt + 32'd1;
      if (w_b_hs) perf_wr_cnt <= perf_wr_cnt + 32'd1;
      perf_stall_cnt <= perf_stall_cnt
                      + {31'd0, w_i_stall}
                      + {31'd0, w_d_stall};
    end
  end
`endif

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: table vectors, directed multi-cycle sequences and
// randomized traffic against a transaction-level reference model.
module tb_cpu_axi_bridge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_axi_bridge_if bus();

`ifdef BRIDGE_PERF_CNT_EN
  logic [31:0] perf_rd_cnt;
  logic [31:0] perf_wr_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  cpu_axi_bridge dut (
    .clk(clk),
    .reset(reset),
`ifdef BRIDGE_PERF_CNT_EN
    .perf_rd_cnt(perf_rd_cnt),
    .perf_wr_cnt(perf_wr_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #4;
  endtask

  task automatic clr_in();
    bus.inst_req   = 1'b0;
    bus.inst_addr  = '0;
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_size  = '0;
    bus.data_wstrb = '0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
    bus.arready    = 1'b0;
    bus.rid        = '0;
    bus.rdata      = '0;
    bus.rvalid     = 1'b0;
    bus.awready    = 1'b0;
    bus.wready     = 1'b0;
    bus.bvalid     = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] fr(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h13572468;
  endfunction

  // Single instruction fetch with an always-ready slave; rvalid one cycle
  // after the AR handshake.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
    bus.inst_req  = 1'b1;
    bus.inst_addr = a;
    bus.arready   = 1'b1;
    smp();
    chk1("f_iaok_c0", bus.inst_addr_ok, 1'b1);
    chk1("f_arv_c0", bus.arvalid, 1'b0);
    tick();
    bus.inst_req = 1'b0;
    smp();
    chk1("f_arv_c1", bus.arvalid, 1'b1);
    chk("f_araddr", bus.araddr, a);
    chk("f_arsize", 32'(bus.arsize), 32'd2);
    chk("f_arid", 32'(bus.arid), 32'd0);
    tick();
    bus.arready = 1'b0;
    smp();
    chk1("f_rready_c2", bus.rready, 1'b1);
    chk1("f_idok_c2", bus.inst_data_ok, 1'b0);
    tick();
    bus.rvalid = 1'b1;
    bus.rid    = 4'd0;
    bus.rdata  = d;
    smp();
    chk1("f_idok_c3", bus.inst_data_ok, 1'b1);
    chk("f_irdata", bus.inst_rdata, d);
    chk1("f_ddok_c3", bus.data_data_ok, 1'b0);
    tick();
    bus.rvalid = 1'b0;
    smp();
    chk1("f_idok_c4", bus.inst_data_ok, 1'b0);
    chk1("f_rready_c4", bus.rready, 1'b0);
  endtask

  typedef struct {
    logic       ireq;
    logic       dreq;
    logic       dwr;
    logic       e_iok;
    logic       e_dok;
    logic       e_arv;
    logic [3:0] e_arid;
    logic       e_awv;
  } vec_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
  } aw_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
  } dp_t;

  vec_t        vt[6];
  ar_t         exp_ar[$];
  aw_t         exp_aw[$];
  dp_t         dpend[$];
  logic [31:0] ipend[$];

  ar_t         ea;
  aw_t         ew;
  dp_t         ed;
  logic [31:0] iad;

  bit          gen;
  bit          ireq_on;
  bit          dreq_on;
  logic [31:0] ia;
  logic        dwr;
  logic [1:0]  dsz;
  logic [31:0] da;
  logic [3:0]  dstrb;
  logic [31:0] dwd;
  bit          wr_out;
  bit          rd_out;
  bit          r_hs;
  bit          b_hs;

  bit          rd_pend;
  logic [31:0] rd_addr;
  logic [3:0]  rd_rid;
  int          rd_dly;
  bit          aw_got;
  bit          w_got;
  bit          b_pend;
  int          b_dly;

  initial begin
    clr_in();
    reset = 1'b1;
    #3;
    chk1("rst_arvalid", bus.arvalid, 1'b0);
    chk1("rst_rready", bus.rready, 1'b0);
    chk1("rst_awvalid", bus.awvalid, 1'b0);
    chk1("rst_wvalid", bus.wvalid, 1'b0);
    chk1("rst_bready", bus.bready, 1'b0);
    chk1("rst_iaok", bus.inst_addr_ok, 1'b0);
    chk1("rst_daok", bus.data_addr_ok, 1'b0);
    chk("rst_irdata", bus.inst_rdata, 32'd0);
    chk("rst_drdata", bus.data_rdata, 32'd0);
    chk("rst_araddr", bus.araddr, 32'd0);
`ifdef BRIDGE_PERF_CNT_EN
    chk("rst_perf_rd", perf_rd_cnt, 32'd0);
    chk("rst_perf_st", perf_stall_cnt, 32'd0);
`endif

    // Arbitration table: one request cycle from idle, then the AXI side.
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      do_reset();
      bus.inst_req   = vt[k].ireq;
      bus.inst_addr  = 32'h1C00_0000 + 32'(k * 4);
      bus.data_req   = vt[k].dreq;
      bus.data_wr    = vt[k].dwr;
      bus.data_size  = 2'd2;
      bus.data_addr  = 32'h0000_2000 + 32'(k * 4);
      bus.data_wdata = 32'hC0DE_0000 + 32'(k);
      bus.data_wstrb = 4'hF;
      smp();
      chk1("tbl_iaok", bus.inst_addr_ok, vt[k].e_iok);
      chk1("tbl_daok", bus.data_addr_ok, vt[k].e_dok);
      tick();
      clr_in();
      smp();
      chk1("tbl_arvalid", bus.arvalid, vt[k].e_arv);
      if (vt[k].e_arv) chk("tbl_arid", 32'(bus.arid), 32'(vt[k].e_arid));
      chk1("tbl_awvalid", bus.awvalid, vt[k].e_awv);
    end

    // Plain fetch: addr_ok c0, arvalid c1, data_ok c3.
    do_reset();
    do_fetch(32'h1C00_0000, 32'h0280_0C0C);
`ifdef BRIDGE_PERF_CNT_EN
    chk("perf_rd_one", perf_rd_cnt, 32'd1);
`endif

    // Simultaneous inst and data load: data first, inst after data_ok.
    do_reset();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1C00_0100;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_1000;
    bus.data_size = 2'd2;
    bus.arready   = 1'b1;
    smp();
    chk1("pr_daok", bus.data_addr_ok, 1'b1);
    chk1("pr_iaok", bus.inst_addr_ok, 1'b0);
    tick();
    bus.data_req = 1'b0;
    smp();
    chk("pr_arid_d", 32'(bus.arid), 32'd1);
    chk("pr_araddr_d", bus.araddr, 32'h0000_1000);
    chk1("pr_iaok_ar", bus.inst_addr_ok, 1'b0);
    tick();
    smp();
    chk1("pr_iaok_r", bus.inst_addr_ok, 1'b0);
    tick();
    bus.rvalid = 1'b1;
    bus.rid    = 4'd1;
    bus.rdata  = 32'h1111_2222;
    smp();
    chk1("pr_ddok", bus.data_data_ok, 1'b1);
    chk("pr_drdata", bus.data_rdata, 32'h1111_2222);
    chk1("pr_idok", bus.inst_data_ok, 1'b0);
    chk1("pr_iaok_rv", bus.inst_addr_ok, 1'b0);
    tick();
    bus.rvalid = 1'b0;
    smp();
    chk1("pr_iaok_late", bus.inst_addr_ok, 1'b1);
    tick();
    bus.inst_req = 1'b0;
    smp();
    chk1("pr_arv_i", bus.arvalid, 1'b1);
    chk("pr_arid_i", 32'(bus.arid), 32'd0);
    chk("pr_araddr_i", bus.araddr, 32'h1C00_0100);

    // Store with awready 3 cycles late, then a same-address load in W_B.
    do_reset();
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b1;
    bus.data_size  = 2'd2;
    bus.data_addr  = 32'h0000_1000;
    bus.data_wdata = 32'hDEAD_BEEF;
    bus.data_wstrb = 4'hF;
    bus.wready     = 1'b1;
    smp();
    chk1("st_daok", bus.data_addr_ok, 1'b1);
    tick();
    bus.data_req = 1'b0;
    smp();
    chk1("st_awv1", bus.awvalid, 1'b1);
    chk1("st_wv1", bus.wvalid, 1'b1);
    chk("st_awaddr", bus.awaddr, 32'h0000_1000);
    chk("st_awsize", 32'(bus.awsize), 32'd2);
    chk("st_wdata", bus.wdata, 32'hDEAD_BEEF);
    chk("st_wstrb", 32'(bus.wstrb), 32'hF);
    tick();
    smp();
    chk1("st_wv2", bus.wvalid, 1'b0);
    chk1("st_awv2", bus.awvalid, 1'b1);
    tick();
    bus.awready = 1'b1;
    smp();
    chk1("st_awv3", bus.awvalid, 1'b1);
    tick();
    bus.awready   = 1'b0;
    bus.data_req  = 1'b1;
    bus.data_wr   = 1'b0;
    bus.data_addr = 32'h0000_1000;
    smp();
    chk1("st_awv4", bus.awvalid, 1'b0);
    chk1("st_bready", bus.bready, 1'b1);
    chk1("raw_daok4", bus.data_addr_ok, 1'b0);
    tick();
    smp();
    chk1("raw_daok5", bus.data_addr_ok, 1'b0);
    chk1("raw_ddok5", bus.data_data_ok, 1'b0);
    tick();
    bus.bvalid = 1'b1;
    smp();
    chk1("st_ddok", bus.data_data_ok, 1'b1);
    chk1("raw_daok6", bus.data_addr_ok, 1'b0);
    tick();
    bus.bvalid  = 1'b0;
    bus.arready = 1'b1;
    smp();
    chk1("raw_daok7", bus.data_addr_ok, 1'b1);
    chk1("raw_ddok7", bus.data_data_ok, 1'b0);
    tick();
    bus.data_req = 1'b0;
    smp();
    chk1("raw_arv", bus.arvalid, 1'b1);
    chk("raw_arid", 32'(bus.arid), 32'd1);
    chk("raw_araddr", bus.araddr, 32'h0000_1000);
`ifdef BRIDGE_PERF_CNT_EN
    chk("perf_wr_one", perf_wr_cnt, 32'd1);
`endif

    // Byte store at an odd address.
    do_reset();
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b1;
    bus.data_size  = 2'd0;
    bus.data_addr  = 32'h0000_1003;
    bus.data_wdata = 32'hAB00_0000;
    bus.data_wstrb = 4'h8;
    smp();
    chk1("bs_daok", bus.data_addr_ok, 1'b1);
    tick();
    bus.data_req = 1'b0;
    smp();
    chk("bs_awsize", 32'(bus.awsize), 32'd0);
    chk("bs_awaddr", bus.awaddr, 32'h0000_1003);
    chk("bs_wstrb", 32'(bus.wstrb), 32'h8);

    // Reset while waiting in R_R abandons the fetch silently.
    do_reset();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1C00_0020;
    bus.arready   = 1'b1;
    smp();
    tick();
    bus.inst_req = 1'b0;
    smp();
    tick();
    smp();
    chk1("mr_rready_pre", bus.rready, 1'b1);
    bus.rvalid = 1'b1;
    bus.rid    = 4'd0;
    bus.rdata  = 32'h5555_AAAA;
    reset      = 1'b1;
    #1;
    chk1("mr_rready", bus.rready, 1'b0);
    chk1("mr_arvalid", bus.arvalid, 1'b0);
    chk1("mr_idok", bus.inst_data_ok, 1'b0);
    chk1("mr_ddok", bus.data_data_ok, 1'b0);
    chk("mr_irdata", bus.inst_rdata, 32'd0);
`ifdef BRIDGE_PERF_CNT_EN
    chk("mr_perf_rd", perf_rd_cnt, 32'd0);
    chk("mr_perf_wr", perf_wr_cnt, 32'd0);
    chk("mr_perf_st", perf_stall_cnt, 32'd0);
`endif
    clr_in();
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_fetch(32'h1C00_0040, 32'h0A0B_0C0D);

    // Randomized traffic against a transaction-level model.
    do_reset();
    ireq_on = 0;
    dreq_on = 0;
    dwr = 1'b0;
    dsz = 2'd0;
    da = '0;
    dstrb = '0;
    dwd = '0;
    ia = '0;
    rd_pend = 0;
    rd_addr = '0;
    rd_rid = '0;
    rd_dly = 0;
    aw_got = 0;
    w_got = 0;
    b_pend = 0;
    b_dly = 0;
    for (int cyc = 0; cyc < 3300; cyc++) begin
      gen = (cyc < 3000);
      tick();
      if (!ireq_on && gen && ipend.size() < 2 &&
          $urandom_range(0, 2) == 0) begin
        ireq_on = 1;
        ia = $urandom & ~32'h3;
      end
      bus.inst_req  = ireq_on;
      bus.inst_addr = ireq_on ? ia : $urandom;
      if (!dreq_on && gen && dpend.size() < 2 &&
          $urandom_range(0, 2) == 0) begin
        dreq_on = 1;
        dwr = 1'($urandom_range(0, 1));
        dsz = 2'($urandom_range(0, 2));
        da = $urandom;
        if (dsz == 2'd1) da[0] = 1'b0;
        if (dsz == 2'd2) da[1:0] = 2'b00;
        if (dsz == 2'd2) dstrb = 4'hF;
        else if (dsz == 2'd1) dstrb = da[1] ? 4'hC : 4'h3;
        else dstrb = 4'(4'b0001 << da[1:0]);
        dwd = $urandom;
      end
      bus.data_req   = dreq_on;
      bus.data_wr    = dwr;
      bus.data_size  = dsz;
      bus.data_addr  = da;
      bus.data_wstrb = dstrb;
      bus.data_wdata = dwd;

      bus.arready = 1'($urandom_range(0, 1));
      if (rd_pend && rd_dly > 0) rd_dly--;
      bus.rvalid = rd_pend && rd_dly == 0;
      bus.rid    = bus.rvalid ? rd_rid : 4'($urandom);
      bus.rdata  = bus.rvalid ? fr(rd_addr) : $urandom;
      bus.awready = 1'($urandom_range(0, 1));
      bus.wready  = 1'($urandom_range(0, 1));
      if (b_pend && b_dly > 0) b_dly--;
      bus.bvalid = b_pend && b_dly == 0;
      smp();

      wr_out = 0;
      rd_out = 0;
      foreach (dpend[j]) begin
        if (dpend[j].wr) wr_out = 1;
        else rd_out = 1;
      end
      if (bus.inst_addr_ok) begin
        chk1("rnd_iaok_req", ireq_on, 1'b1);
        chk1("rnd_data_prio", dreq_on && !dwr && !wr_out, 1'b0);
        ipend.push_back(ia);
        exp_ar.push_back('{4'd0, ia, 3'd2});
        ireq_on = 0;
      end
      if (bus.data_addr_ok) begin
        chk1("rnd_daok_req", dreq_on, 1'b1);
        if (dwr) begin
          chk1("rnd_wr_vs_rd", rd_out, 1'b0);
          exp_aw.push_back('{da, {1'b0, dsz}, dwd, dstrb});
        end else begin
          chk1("rnd_rd_vs_wr", wr_out, 1'b0);
          exp_ar.push_back('{4'd1, da, {1'b0, dsz}});
        end
        dpend.push_back('{dwr, da});
        dreq_on = 0;
      end

      r_hs = bus.rvalid && bus.rready;
      b_hs = bus.bvalid && bus.bready;
      chk1("rnd_idok", bus.inst_data_ok, r_hs && bus.rid != 4'd1);
      chk1("rnd_ddok", bus.data_data_ok,
           (r_hs && bus.rid == 4'd1) || b_hs);
      if (bus.inst_data_ok) begin
        chk("rnd_ipend", 32'(ipend.size()), 32'd1);
        if (ipend.size() > 0) begin
          iad = ipend.pop_front();
          chk("rnd_irdata", bus.inst_rdata, fr(iad));
        end
      end
      if (bus.data_data_ok) begin
        chk("rnd_dpend", 32'(dpend.size()), 32'd1);
        if (dpend.size() > 0) begin
          ed = dpend.pop_front();
          if (!ed.wr) chk("rnd_drdata", bus.data_rdata, fr(ed.addr));
        end
      end

      if (r_hs) rd_pend = 0;
      if (bus.arvalid && bus.arready) begin
        chk("rnd_ar_exp", 32'(exp_ar.size()), 32'd1);
        if (exp_ar.size() > 0) begin
          ea = exp_ar.pop_front();
          chk("rnd_arid", 32'(bus.arid), 32'(ea.id));
          chk("rnd_araddr", bus.araddr, ea.addr);
          chk("rnd_arsize", 32'(bus.arsize), 32'(ea.size));
          rd_pend = 1;
          rd_addr = ea.addr;
          if (ea.id == 4'd1) rd_rid = 4'd1;
          else rd_rid = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'd0;
          rd_dly = $urandom_range(0, 3);
        end
      end

      if (b_hs) b_pend = 0;
      if (bus.awvalid && bus.awready) begin
        chk1("rnd_aw_once", aw_got, 1'b0);
        aw_got = 1;
        if (exp_aw.size() > 0) begin
          chk("rnd_awaddr", bus.awaddr, exp_aw[0].addr);
          chk("rnd_awsize", 32'(bus.awsize), 32'(exp_aw[0].size));
        end
      end
      if (bus.wvalid && bus.wready) begin
        chk1("rnd_w_once", w_got, 1'b0);
        w_got = 1;
        if (exp_aw.size() > 0) begin
          chk("rnd_wdata", bus.wdata, exp_aw[0].data);
          chk("rnd_wstrb", 32'(bus.wstrb), 32'(exp_aw[0].strb));
        end
      end
      if (aw_got && w_got) begin
        chk("rnd_aw_exp", 32'(exp_aw.size()), 32'd1);
        if (exp_aw.size() > 0) ew = exp_aw.pop_front();
        aw_got = 0;
        w_got = 0;
        b_pend = 1;
        b_dly = $urandom_range(0, 3);
      end
    end
    chk("drain_inst", 32'(ipend.size()) + 32'(ireq_on), 32'd0);
    chk("drain_data", 32'(dpend.size()) + 32'(dreq_on), 32'd0);
    chk("drain_ar", 32'(exp_ar.size()), 32'd0);
    chk("drain_aw", 32'(exp_aw.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Converts the core's two SRAM-like request ports (instruction fetch, data load/store) into a single AXI3 master port.
- Sits directly downstream of the CPU top's inst/data memory interfaces, between the core and the SoC AXI interconnect.
- Handles one outstanding read and one outstanding write.
- Arbitrates reads with data priority.

Parameters:
- ID_INST, 4'd0, ARID used for instruction reads.
- ID_DATA, 4'd1, ARID/AWID used for data accesses.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- inst_req  in  1  fetch request valid
- inst_addr  in  32  fetch byte address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data returned this cycle
- inst_rdata  out  32  fetch data
- data_req  in  1  data request valid
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  store byte strobes
- data_addr  in  32  data byte address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data / store response this cycle
- data_rdata  out  32  load data
- arid  out  4  read id
- araddr  out  32  read address
- arsize  out  3  read size
- arvalid  out  1  read address valid
- arready  in  1  read address ready
- rid  in  4  read data id
- rdata  in  32  read data
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- awaddr  out  32  write address
- awsize  out  3  write size
- awvalid  out  1  write address valid
- awready  in  1  write address ready
- wdata  out  32  write data
- wstrb  out  4  write strobes
- wvalid  out  1  write data valid
- wready  in  1  write data ready
- bvalid  in  1  write response valid
- bready  out  1  write response ready

Behaviour:
- Fixed AXI fields are driven at the SoC wrapper: len = 0, burst = INCR, lock/cache/prot = 0, wid = 1, wlast = 1. All bridge transfers are single beat.
- Reset (async, active-high): both FSMs go to IDLE; all valid/ready/ok outputs 0; rdata outputs 0; latched registers 0.

Read FSM: R_IDLE -> R_AR -> R_R -> R_IDLE.
- R_IDLE, candidate selection:
  - data candidate = data_req & ~data_wr & write FSM == W_IDLE (conservative RAW block).
  - inst candidate = inst_req.
  - Data wins when both are present.
- R_IDLE, acceptance:
  - The winner's addr_ok is asserted combinationally that cycle.
  - The bridge latches addr, id and size (inst size = 2) and moves to R_AR.
  - The losing port sees addr_ok = 0 and keeps req.
- R_AR: arvalid = 1 with latched fields. On arready, go to R_R. arvalid stays 1 until the handshake.
- R_R: rready = 1. On rvalid:
  - rid == ID_DATA: data_data_ok = 1, data_rdata = rdata for exactly that cycle.
  - otherwise: inst_data_ok = 1, inst_rdata = rdata for exactly that cycle.
  - Then go to R_IDLE.
  - Minimum latency: addr_ok at cycle 0, arvalid at cycle 1, data_ok at cycle 2 or later.

Write FSM: W_IDLE -> W_SEND -> W_B -> W_IDLE.
- W_IDLE: accepts data_req & data_wr when the read FSM is not in R_AR/R_R with a data read.
  - data_addr_ok = 1; latch addr, size, wstrb, wdata.
  - awsize = {1'b0, size}.
- W_SEND: awvalid and wvalid both asserted on entry. Each deasserts independently after its own handshake. When both are done, go to W_B; either order or the same cycle is legal.
- W_B: bready = 1. On bvalid: data_data_ok = 1, go to W_IDLE.

Conflict rules:
- data_addr_ok is never asserted for a read and a write in the same cycle; the data port carries a single request.
- An instruction read may proceed while a write is outstanding.
- data_data_ok from a read completion and from a B response can never coincide: a data read is blocked while a write is outstanding.
- rid other than ID_INST/ID_DATA is treated as inst.
- Reset mid-transaction abandons the transaction; no ok pulses are issued.

Optional Feature:
- Macro BRIDGE_PERF_CNT_EN.
- With it: adds outputs perf_rd_cnt[31:0], perf_wr_cnt[31:0], perf_stall_cnt[31:0].
  - perf_rd_cnt increments on each R handshake.
  - perf_wr_cnt increments on each B handshake.
  - perf_stall_cnt increments each cycle a req is high with its addr_ok low.
  - All counters wrap at 2^32 and reset to 0.
- Without it: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- inst_req, addr 0x1C000000; arready=1, rvalid 1 cycle after AR with rdata 0x02800C0C, rid 0 -> inst_addr_ok cycle 0, arvalid cycle 1, inst_data_ok with rdata 0x02800C0C cycle 3.
- inst_req and data load 0x00001000 raised same cycle -> data_addr_ok first, arid=1; inst accepted only after data_data_ok; inst then gets arid=0.
- Store word 0x00001000, wdata 0xDEADBEEF, wstrb 0xF; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles, data_data_ok on bvalid.
- Store pending in W_B and a load to the same address requested -> data_addr_ok stays 0 until the write's data_data_ok, then the load issues.
- Byte store size 0, addr 0x00001003, wstrb 0x8 -> awsize=0, awaddr=0x00001003, wstrb=0x8.
- Assert reset during R_R -> arvalid/rready/ok outputs 0 immediately; after release the next inst_req completes normally; with BRIDGE_PERF_CNT_EN, counters read 0.
